// File: rtl/decrementer_pkg.sv
// Shared width constant and word type for the decrement-by-one datapath.
package decrementer_pkg;
  localparam int DEC_WIDTH = 8;
  typedef logic [DEC_WIDTH-1:0] dec_word_t;
endpackage

// File: rtl/half_subtractor.sv
// One ripple-borrow cell: subtracts the incoming borrow from a single bit.
module half_subtractor (
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ bin;
  assign bout = ~a & bin;
endmodule

// File: rtl/decrementer_8b.sv
// Unsigned decrement-by-one: combinational D = A - 1 with borrow-out,
// plus a one-cycle registered copy for pipelined consumers.
module decrementer_8b
  import decrementer_pkg::*;
#(
  parameter int WIDTH = DEC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] D,
  output logic             Borrow,
  output logic [WIDTH-1:0] D_q,
  output logic             Borrow_q
);
  // borrow_chain[0] is the constant "subtract one"; the top tap is the wrap flag.
  logic [WIDTH:0] borrow_chain;

  assign borrow_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      half_subtractor u_cell (
        .a    (A[gi]),
        .bin  (borrow_chain[gi]),
        .d    (D[gi]),
        .bout (borrow_chain[gi+1])
      );
    end
  endgenerate

  assign Borrow = borrow_chain[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D_q      <= '0;
      Borrow_q <= 1'b0;
    end else begin
      D_q      <= D;
      Borrow_q <= Borrow;
    end
  end
endmodule

// File: tb/tb_decrementer_8b.sv
// Self-checking bench for decrementer_8b: directed corners, full sweep and async reset.
module tb_decrementer_8b;
  import decrementer_pkg::*;

  logic      clk;
  logic      rst_n;
  dec_word_t A;
  dec_word_t D;
  logic      Borrow;
  dec_word_t D_q;
  logic      Borrow_q;

  int checks;
  int failures;

  // Expected {D_q, Borrow_q} for the next clock edge.
  logic [DEC_WIDTH:0] exp_q[$];

  decrementer_8b dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .D        (D),
    .Borrow   (Borrow),
    .D_q      (D_q),
    .Borrow_q (Borrow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive A between edges, check the combinational outputs, queue the registered
  // expectation, then compare it one rising edge later.
  task automatic step(input int a_val, input string tag);
    logic [DEC_WIDTH-1:0] exp_d;
    logic                 exp_b;
    logic [DEC_WIDTH:0]   item;
    @(negedge clk);
    A = a_val[DEC_WIDTH-1:0];
    #1;
    exp_d = DEC_WIDTH'((a_val + 255) % 256);
    exp_b = (a_val == 0);
    check({tag, "_d"}, 32'(D), 32'(exp_d));
    check({tag, "_borrow"}, 32'(Borrow), 32'(exp_b));
    exp_q.push_back({exp_d, exp_b});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      item = exp_q.pop_front();
      check({tag, "_d_q"}, 32'(D_q), 32'(item[DEC_WIDTH:1]));
      check({tag, "_borrow_q"}, 32'(Borrow_q), 32'(item[0]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    A        = '0;
    #2;
    check("reset_d_q", 32'(D_q), 32'd0);
    check("reset_borrow_q", 32'(Borrow_q), 32'd0);
    check("reset_comb_d", 32'(D), 32'd255);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, "a0");
    step(1, "a1");
    step(10, "a10");
    step(255, "a255");

    for (int i = 0; i < 256; i++) begin
      step(i, "sweep");
    end

    // Registers now hold 255/1 from A = 0; reset between edges must clear them at once.
    step(0, "pre_reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_d_q", 32'(D_q), 32'd0);
    check("async_rst_borrow_q", 32'(Borrow_q), 32'd0);
    check("async_rst_d", 32'(D), 32'd255);
    check("async_rst_borrow", 32'(Borrow), 32'd1);
    @(posedge clk);
    #1;
    check("held_rst_d_q", 32'(D_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_clk_d_q", 32'(D_q), 32'd0);
    check("release_no_clk_borrow_q", 32'(Borrow_q), 32'd0);
    @(posedge clk);
    #1;
    check("reload_d_q", 32'(D_q), 32'd255);
    check("reload_borrow_q", 32'(Borrow_q), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decrementer_8b.md
Name: decrementer_8b

Overview:
Unsigned 8-bit decrement-by-one unit: D = A - 1, with a borrow-out flag that marks wrap-around from 0.
The arithmetic path is purely combinational, with zero latency.
A registered copy of the result is also provided for pipelined consumers.
The block sits in the datapath wherever a count or address must be stepped down by one.

Parameters:
WIDTH, 8, operand/result width in bits. The 8-bit configuration is the one required and verified.

Ports:
clk  input  1  rising-edge clock; drives only the registered outputs.
rst_n  input  1  asynchronous, active-low reset; affects only the registered outputs.
A  input  WIDTH  unsigned operand.
D  output  WIDTH  combinational result, A - 1 modulo 2^WIDTH.
Borrow  output  1  combinational borrow-out; 1 exactly when A == 0.
D_q  output  WIDTH  D registered on the rising edge of clk.
Borrow_q  output  1  Borrow registered on the rising edge of clk.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational path:
  - D = A - 1 mod 2^WIDTH.
  - Borrow = (A == 0).
  - Both settle within the same delta/cycle as A changes; no clock involvement.
- Implementation: ripple-borrow chain of WIDTH half-subtractor cells.
  - Borrow-in of bit 0 is tied to 1.
  - Per cell: d[i] = a[i] XOR bin[i]; bout[i] = (NOT a[i]) AND bin[i]; bin[i+1] = bout[i].
  - Borrow = bout[WIDTH-1].
- Boundary conditions:
  - A = 0 → D = all ones (255), Borrow = 1 (wrap-around).
  - A = 255 → D = 254, Borrow = 0.
  - For any A ≠ 0, Borrow = 0.
- Registered path:
  - On each rising clk edge, D_q <= D and Borrow_q <= Borrow. Latency is 1 cycle from A to D_q/Borrow_q.
  - While rst_n = 0: D_q = 0 and Borrow_q = 0 immediately, with no clock needed.
  - Release of rst_n takes effect at the first rising clk edge after deassertion.
  - Reset mid-operation clears only the registers; D/Borrow continue to follow A.
- No X propagation: with a known A, all outputs are known after reset.
- No internal state other than the two output registers.

Decomposition:
- Shared package `decrementer_pkg`:
  - constant DEC_WIDTH = 8.
  - typedef dec_word_t = logic [DEC_WIDTH-1:0].
- One sub-module: `half_subtractor` (ports a, bin, d, bout), instantiated WIDTH times through a generate loop.
- The register stage stays in the top module.

Test Plan:
- Check the combinational outputs at each step; for the registered path, hold rst_n = 1 and check D_q/Borrow_q one clock edge after each A step.
- A = 0 → D = 255 (1111_1111), Borrow = 1; after one clk edge D_q = 255, Borrow_q = 1.
- A = 1 → D = 0, Borrow = 0; after one clk edge D_q = 0, Borrow_q = 0.
- A = 10 → D = 9 (0000_1001), Borrow = 0.
- A = 255 → D = 254 (1111_1110), Borrow = 0.
- Exhaustive sweep A = 0..255, compared against a reference model:
  - D == (A + 255) mod 256.
  - Borrow == (A == 0).
  - D_q/Borrow_q match the previous cycle's D/Borrow.
- Reset: with A = 0 and registers holding 255/1, assert rst_n = 0 between clock edges → D_q = 0 and Borrow_q = 1→0 immediately, while D stays 255 and Borrow stays 1. Deassert rst_n → registers reload 255/1 on the next clk edge.
